// File: rtl/dma_pkg.sv
// Shared DMA constants: command mailbox address, command field layout, address width and FSM states.
// Pure declarations; no latency or backpressure of its own.
package dma_pkg;
  localparam logic [31:0] DMA_CMD_ADDR = 32'd5000;
  localparam int ADDR_W  = 9;
  localparam int SRC_LSB = 17;
  localparam int SRC_W   = 9;
  localparam int DST_LSB = 8;
  localparam int DST_W   = 9;
  localparam int CNT_LSB = 0;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RD,
    ST_WR,
    ST_DONE
  } dma_state_e;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [DST_W-1:0] dst;
    logic [CNT_W-1:0] cnt;
  } dma_cmd_t;
endpackage

// File: rtl/dma_if.sv
// CPU-side strobes and DMA status/grant signals; IRQ exists only when DMA_IRQ_EN is defined.
// No latency; the CPU must stall and tristate the buses while ADE is high.
interface dma_if;
  logic Read;
  logic Write;
  logic ADE;
  logic DMA_Read;
  logic DMA_Write;
  logic Busy;
`ifdef DMA_IRQ_EN
  logic IRQ;
  modport master (output Read, Write, input ADE, DMA_Read, DMA_Write, Busy, IRQ);
  modport slave  (input Read, Write, output ADE, DMA_Read, DMA_Write, Busy, IRQ);
`else
  modport master (output Read, Write, input ADE, DMA_Read, DMA_Write, Busy);
  modport slave  (input Read, Write, output ADE, DMA_Read, DMA_Write, Busy);
`endif
endinterface

// File: rtl/dma_cmd_decode.sv
// Recognises a CPU store to the command mailbox and splits it into SRC/DST/CNT; zero-length commands never validate.
// Combinational, zero latency; no backpressure (the FSM ignores cmd_vld_o outside IDLE).
module dma_cmd_decode
  import dma_pkg::*;
(
  input  logic        ade_i,
  input  logic [31:0] addr_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] data_i,
  output logic        cmd_vld_o,
  output dma_cmd_t    cmd_o
);
  assign cmd_o.src = data_i[SRC_LSB +: SRC_W];
  assign cmd_o.dst = data_i[DST_LSB +: DST_W];
  assign cmd_o.cnt = data_i[CNT_LSB +: CNT_W];

  assign cmd_vld_o = !ade_i && (addr_i == DMA_CMD_ADDR) && !read_i && !write_i
                     && (cmd_o.cnt != '0);
endmodule

// File: rtl/dma_controller.sv
// Memory-to-memory copier: one RD and one WR cycle per word, bracketed by GRANT and DONE (2*CNT+2 cycles of ADE).
// Commands seen while busy are dropped; optional one-cycle IRQ in DONE under DMA_IRQ_EN.
module dma_controller
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  inout  wire  [31:0] address_Bus,
  inout  wire  [31:0] Data_Bus,
  dma_if.slave        bus
);
  dma_state_e         state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [DST_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [31:0]        buf_q, buf_d;
  logic               cmd_vld;
  dma_cmd_t           cmd;
  logic [ADDR_W-1:0]  cur_addr;
  logic               in_rd, in_wr, granted;

  dma_cmd_decode u_decode (
    .ade_i     (granted),
    .addr_i    (address_Bus),
    .read_i    (bus.Read),
    .write_i   (bus.Write),
    .data_i    (Data_Bus),
    .cmd_vld_o (cmd_vld),
    .cmd_o     (cmd)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          state_d = ST_GRANT;
          src_d   = cmd.src;
          dst_d   = cmd.dst;
          cnt_d   = cmd.cnt;
          idx_d   = '0;
        end
      end
      ST_GRANT: state_d = ST_RD;
      ST_RD: begin
        buf_d   = Data_Bus;
        state_d = ST_WR;
      end
      ST_WR: begin
        idx_d   = idx_q + 8'd1;
        state_d = ((idx_q + 8'd1) < cnt_q) ? ST_RD : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only, so nothing follows the inputs combinationally.
  assign granted  = (state_q != ST_IDLE);
  assign in_rd    = (state_q == ST_RD);
  assign in_wr    = (state_q == ST_WR);
  assign cur_addr = (in_wr ? dst_q : src_q) + ADDR_W'(idx_q);

  assign bus.ADE       = granted;
  assign bus.Busy      = granted;
  assign bus.DMA_Read  = in_rd;
  assign bus.DMA_Write = in_wr;

  assign address_Bus = (in_rd || in_wr) ? {23'b0, cur_addr} : 'z;
  assign Data_Bus    = in_wr ? buf_q : 'z;

`ifdef DMA_IRQ_EN
  assign bus.IRQ = (state_q == ST_DONE);
`endif
endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: CPU plus 512x32 combinational-read memory, checked against an in-order copy model.
module tb_dma_controller;
  logic        CLK = 1'b0;
  logic        RST;
  wire  [31:0] address_Bus;
  wire  [31:0] Data_Bus;
  dma_if       bus ();

  logic        cpu_drv;
  logic [31:0] cpu_addr, cpu_dat;
  logic        cpu_en;
  logic        fill_req;
  logic [31:0] mem [512];
  logic [31:0] exp_mem [512];
  int          rd_log [$];
  int          wr_log [$];
  int          viol;
  int          vec, errs;
  int          irq_n, irq_at;

  always #5 CLK = ~CLK;

  dma_controller dut (
    .CLK         (CLK),
    .RST         (RST),
    .address_Bus (address_Bus),
    .Data_Bus    (Data_Bus),
    .bus         (bus)
  );

  // The CPU only reaches the buses while the DMA is not strobing memory.
  assign cpu_en      = cpu_drv && !bus.DMA_Read && !bus.DMA_Write;
  assign address_Bus = cpu_en ? cpu_addr : 'z;
  assign Data_Bus    = cpu_en ? cpu_dat : 'z;
  assign Data_Bus    = bus.DMA_Read ? mem[address_Bus[8:0]] : 'z;

  always @(posedge CLK) begin
    if (fill_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= $urandom;
    end else if (bus.DMA_Write) begin
      mem[address_Bus[8:0]] <= Data_Bus;
    end
  end

  always @(negedge CLK) begin
    if (bus.DMA_Read) rd_log.push_back(int'(address_Bus[8:0]));
    if (bus.DMA_Write) wr_log.push_back(int'(address_Bus[8:0]));
    if (bus.DMA_Read && bus.DMA_Write) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) exp_mem[(d + i) % 512] = exp_mem[(s + i) % 512];
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic issue(input int s, input int d, input int c);
    cpu_addr = 32'd5000;
    cpu_dat  = {6'b0, 9'(s), 9'(d), 8'(c)};
    cpu_drv  = 1'b1;
    @(negedge CLK);
    cpu_drv  = 1'b0;
  endtask

  // Counts negedges with ADE high, starting at the current negedge.
  task automatic wait_done(output int n);
    n = 0; irq_n = 0; irq_at = 0;
    while (bus.ADE && n < 1200) begin
`ifdef DMA_IRQ_EN
      if (bus.IRQ) begin irq_n++; irq_at = n + 1; end
`endif
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic copy_test(input string tag, input int s, input int d, input int c);
    int n;
    rd_log.delete(); wr_log.delete(); viol = 0;
    issue(s, d, c);
    wait_done(n);
    model_copy(s, d, c);
    chk({tag, "_ade_cycles"}, n, 2 * c + 2);
    chk({tag, "_rd_count"}, rd_log.size(), c);
    for (int i = 0; i < c && i < rd_log.size(); i++)
      chk({tag, "_rd_addr"}, rd_log[i], (s + i) % 512);
    chk({tag, "_strobe_excl"}, viol, 0);
    chk({tag, "_mem"}, mem_diff(), 0);
`ifdef DMA_IRQ_EN
    chk({tag, "_irq_count"}, irq_n, 1);
    chk({tag, "_irq_cycle"}, irq_at, 2 * c + 2);
`endif
  endtask

  initial begin
    int n, act, s, d, c;
    vec = 0; errs = 0; viol = 0;
    cpu_drv = 1'b0; cpu_addr = '0; cpu_dat = '0;
    bus.Read = 1'b0; bus.Write = 1'b0;
    RST = 1'b1; fill_req = 1'b1;
    @(negedge CLK);
    fill_req = 1'b0;
    @(negedge CLK);
    chk("rst_ade", bus.ADE, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_dma_read", bus.DMA_Read, 0);
    chk("rst_dma_write", bus.DMA_Write, 0);
`ifdef DMA_IRQ_EN
    chk("rst_irq", bus.IRQ, 0);
`endif
    for (int i = 0; i < 512; i++) exp_mem[i] = mem[i];
    RST = 1'b0;
    @(negedge CLK);

    copy_test("basic", 10, 100, 4);

    issue(30, 60, 0);
    act = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.ADE || bus.Busy || bus.DMA_Read || bus.DMA_Write) act++;
      @(negedge CLK);
    end
    chk("cnt0_activity", act, 0);
    chk("cnt0_mem", mem_diff(), 0);

    copy_test("wrap", 510, 20, 4);
    copy_test("overlap_up", 50, 52, 6);
    copy_test("overlap_dn", 80, 77, 5);
    copy_test("single", 300, 301, 1);

    for (int t = 0; t < 4; t++) begin
      s = $urandom_range(0, 511);
      d = $urandom_range(0, 511);
      c = $urandom_range(1, 24);
      copy_test("rand", s, d, c);
    end

    bus.Write = 1'b1;
    issue(5, 6, 3);
    bus.Write = 1'b0;
    act = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.ADE) act++;
      @(negedge CLK);
    end
    chk("strobe_cmd_ignored", act, 0);

    // Second command driven during GRANT, when the DMA has the grant but leaves the buses free.
    rd_log.delete(); wr_log.delete();
    issue(200, 300, 3);
    cpu_addr = 32'd5000;
    cpu_dat  = {6'b0, 9'd0, 9'd400, 8'd2};
    cpu_drv  = 1'b1;
    @(negedge CLK);
    cpu_drv  = 1'b0;
    wait_done(n);
    model_copy(200, 300, 3);
    chk("busy_ade_cycles", n + 1, 8);
    chk("busy_wr_count", wr_log.size(), 3);
    act = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.ADE) act++;
      @(negedge CLK);
    end
    chk("busy_no_second", act, 0);
    chk("busy_mem", mem_diff(), 0);

    // Reset during the WR of the second word of a 5-word copy.
    rd_log.delete(); wr_log.delete();
    issue(120, 140, 5);
    n = 0;
    while (wr_log.size() < 2 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid_reached", wr_log.size(), 2);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_ade", bus.ADE, 0);
    chk("rst_mid_busy", bus.Busy, 0);
    chk("rst_mid_dma_write", bus.DMA_Write, 0);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge CLK);
    model_copy(120, 140, 2);
    chk("rst_mid_writes", wr_log.size(), 2);
    chk("rst_mid_mem", mem_diff(), 0);

    RST = 1'b1;
    issue(7, 9, 2);
    RST = 1'b0;
    act = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.ADE) act++;
      @(negedge CLK);
    end
    chk("rst_cmd_dropped", act, 0);

    copy_test("after_rst", 400, 410, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
